// File: rtl/seq_divider.sv
`default_nettype none
//============================================================================
// Module      : seq_divider
// Description : Sequential signed-by-unsigned divider with round-half-away-
//               from-zero rounding and saturation on divide-by-zero.
//               One restoring-division step per cycle, MSB first, on the
//               dividend magnitude; the sign is re-applied after rounding.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Ports
//   clk           in   clock, rising edge
//   nrst          in   asynchronous active-low reset
//   din_dividend  in   WIDTH-bit signed dividend
//   din_divisor   in   DWIDTH-bit unsigned divisor
//   din_valid     in   operands valid
//   din_ready     out  high only while idle; accept = din_valid & din_ready
//   dout_quotient out  WIDTH-bit signed rounded quotient
//   dout_dbz      out  divisor was zero for the presented result
//   dout_valid    out  result valid (held until dout_ready)
//   dout_ready    in   downstream takes the result
//============================================================================
module seq_divider #(
    parameter int WIDTH  = 12,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [WIDTH-1:0]  din_dividend,
    input  logic [DWIDTH-1:0] din_divisor,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [WIDTH-1:0]  dout_quotient,
    output logic              dout_dbz,
    output logic              dout_valid,
    input  logic              dout_ready
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Datapath registers: meaningful only between accept and DONE.
    logic              neg;
    logic [WIDTH-1:0]  mag;   // dividend magnitude, shifted out MSB first; quotient bits shift in
    logic [DWIDTH:0]   rem;   // partial remainder, always < divisor
    logic [DWIDTH-1:0] div;
    logic [CW-1:0]     cnt;

    logic              accept;
    logic [WIDTH-1:0]  dividend_abs;
    logic [DWIDTH:0]   trial;
    logic [DWIDTH:0]   trial_sub;
    logic              fits;
    logic              round_up;
    logic [WIDTH-1:0]  q_round;
    logic [WIDTH-1:0]  q_signed;
    logic [WIDTH-1:0]  q_sat;

    assign din_ready  = (state == IDLE);
    assign dout_valid = (state == DONE);
    assign accept     = din_valid && (state == IDLE);

    // Magnitude of the most negative dividend is 2^(WIDTH-1), which still fits
    // in WIDTH unsigned bits, so no overflow case exists here.
    assign dividend_abs = din_dividend[WIDTH-1]
                        ? (~din_dividend + {{(WIDTH-1){1'b0}}, 1'b1})
                        : din_dividend;

    // Remainder is below the divisor, so dropping its top bit before the
    // shift is lossless.
    assign trial     = {rem[DWIDTH-1:0], mag[WIDTH-1]};
    assign fits      = (trial >= {1'b0, div});
    assign trial_sub = trial - {1'b0, div};

    // 2R >= b: round half away from zero on the magnitude. The increment can
    // only push Q past 2^(WIDTH-1)-1 when b==1, and then R==0.
    assign round_up = ({rem, 1'b0} >= {2'b00, div});
    assign q_round  = mag + {{(WIDTH-1){1'b0}}, round_up};
    assign q_signed = neg ? (~q_round + {{(WIDTH-1){1'b0}}, 1'b1}) : q_round;

    assign q_sat = din_dividend[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (din_divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nxt = ROUND;
                end
            end
            ROUND: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (dout_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: intentionally without reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            neg <= din_dividend[WIDTH-1];
            mag <= dividend_abs;
            rem <= '0;
            div <= din_divisor;
            cnt <= '0;
        end else if (state == CALC) begin
            rem <= fits ? trial_sub : trial;
            mag <= {mag[WIDTH-2:0], fits};
            cnt <= cnt + 1'b1;
        end
    end

    // Result registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            dout_quotient <= '0;
            dout_dbz      <= 1'b0;
        end else if (accept) begin
            if (din_divisor == '0) begin
                dout_quotient <= q_sat;
                dout_dbz      <= 1'b1;
            end else begin
                dout_dbz      <= 1'b0;
            end
        end else if (state == ROUND) begin
            dout_quotient <= q_signed;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
`timescale 1ns/1ps
//============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider: directed vector table,
//               backpressure and reset-abort sequences, random regression
//               against an arithmetic reference model.
// Revision    : 1.0 - initial release
//============================================================================
module tb_seq_divider;

    localparam int W  = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [W-1:0]  din_dividend = '0;
    logic [DW-1:0] din_divisor = '0;
    logic          din_valid = 1'b0;
    logic          din_ready;
    logic [W-1:0]  dout_quotient;
    logic          dout_dbz;
    logic          dout_valid;
    logic          dout_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    seq_divider #(.WIDTH(W), .DWIDTH(DW)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .din_dividend  (din_dividend),
        .din_divisor   (din_divisor),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .dout_quotient (dout_quotient),
        .dout_dbz      (dout_dbz),
        .dout_valid    (dout_valid),
        .dout_ready    (dout_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int q;
        int dbz;
        int lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: round half away from zero on |a|/b, sign reapplied,
    // saturate to the signed range when b==0.
    function automatic void ref_div(input int a, input int b, output int q,
                                    output int dbz, output int lat);
        int m;
        int r;
        if (b == 0) begin
            q   = (a < 0) ? -(1 << (W-1)) : (1 << (W-1)) - 1;
            dbz = 1;
            lat = 1;
        end else begin
            m = (a < 0) ? -a : a;
            q = m / b;
            r = m % b;
            if (2 * r >= b) q = q + 1;
            if (a < 0) q = -q;
            dbz = 0;
            lat = W + 2;
        end
    endfunction

    // Issue one operation; latency counts edges from the accepting edge
    // (inclusive) to the first edge after which dout_valid is seen high.
    task automatic run_op(input int a, input int b, input bit release_out,
                          output int q, output int dbz, output int lat);
        int guard = 0;
        while (!din_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        din_dividend = a[W-1:0];
        din_divisor  = b[DW-1:0];
        din_valid    = 1'b1;
        @(posedge clk); #1;
        // Garbage while busy must be ignored.
        din_dividend = W'($urandom);
        din_divisor  = DW'($urandom);
        lat = 1;
        while (!dout_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        q   = int'($signed(dout_quotient));
        dbz = int'(dout_dbz);
        din_valid = 1'b0;
        if (release_out) begin
            dout_ready = 1'b1;
            @(posedge clk); #1;
            dout_ready = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[13];
        int q, dbz, lat, eq, edbz, elat;
        int hq, hdbz;
        int a, b;
        bit saw_valid;

        vecs[0]  = '{100,   16,  6,     0, 14};
        vecs[1]  = '{-100,  16,  -6,    0, 14};
        vecs[2]  = '{24,    16,  2,     0, 14};
        vecs[3]  = '{-24,   16,  -2,    0, 14};
        vecs[4]  = '{7,     16,  0,     0, 14};
        vecs[5]  = '{8,     16,  1,     0, 14};
        vecs[6]  = '{0,     5,   0,     0, 14};
        vecs[7]  = '{-2048, 1,   -2048, 0, 14};
        vecs[8]  = '{2047,  1,   2047,  0, 14};
        vecs[9]  = '{2047,  255, 8,     0, 14};
        vecs[10] = '{-2048, 255, -8,    0, 14};
        vecs[11] = '{5,     0,   2047,  1, 1};
        vecs[12] = '{-5,    0,   -2048, 1, 1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout_valid", dout_valid, 0);
        chk("reset dout_quotient", dout_quotient, 0);
        chk("reset dout_dbz", dout_dbz, 0);
        nrst = 1'b1;
        @(posedge clk); #1;
        chk("post-reset din_ready", din_ready, 1);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b1, q, dbz, lat);
            chk($sformatf("vec%0d quotient", i), q, vecs[i].q);
            chk($sformatf("vec%0d dbz", i), dbz, vecs[i].dbz);
            chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
            chk($sformatf("vec%0d din_ready after handoff", i), din_ready, 1);
        end

        // Backpressure: hold result for 10 cycles
        ref_div(300, 7, eq, edbz, elat);
        run_op(300, 7, 1'b0, hq, hdbz, lat);
        chk("bp quotient", hq, eq);
        chk("bp latency", lat, elat);
        din_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            din_dividend = W'($urandom);
            din_divisor  = DW'($urandom);
            @(posedge clk); #1;
            chk("bp hold quotient", int'($signed(dout_quotient)), hq);
            chk("bp hold dbz", dout_dbz, hdbz);
            chk("bp hold dout_valid", dout_valid, 1);
            chk("bp hold din_ready", din_ready, 0);
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        @(posedge clk); #1;
        dout_ready = 1'b0;
        chk("bp release din_ready", din_ready, 1);
        chk("bp release dout_valid", dout_valid, 0);
        ref_div(-77, 3, eq, edbz, elat);
        run_op(-77, 3, 1'b1, q, dbz, lat);
        chk("bp back-to-back quotient", q, eq);
        chk("bp back-to-back latency", lat, elat);

        // Reset in the middle of CALC
        din_dividend = 12'd100;
        din_divisor  = 8'd16;
        din_valid    = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        nrst = 1'b0;
        #2;
        chk("mid-reset dout_valid", dout_valid, 0);
        chk("mid-reset dout_quotient", dout_quotient, 0);
        chk("mid-reset dout_dbz", dout_dbz, 0);
        #2;
        nrst = 1'b1;
        saw_valid = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (dout_valid) saw_valid = 1'b1;
        end
        chk("aborted op never valid", saw_valid, 0);
        chk("after abort din_ready", din_ready, 1);
        run_op(100, 16, 1'b1, q, dbz, lat);
        chk("after abort 100/16", q, 6);
        chk("after abort latency", lat, 14);

        // Random regression
        for (int n = 0; n < 300; n++) begin
            a = int'($urandom_range(0, 4095)) - 2048;
            b = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(0, 255));
            ref_div(a, b, eq, edbz, elat);
            run_op(a, b, 1'b1, q, dbz, lat);
            chk($sformatf("rand %0d/%0d quotient", a, b), q, eq);
            chk($sformatf("rand %0d/%0d dbz", a, b), dbz, edbz);
            chk($sformatf("rand %0d/%0d latency", a, b), lat, elat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 12, meaning the width of the signed dividend and of the quotient.
REQ-002 SHALL have parameter DWIDTH, default 8, meaning the width of the unsigned divisor (quantisation step).
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port nrst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port din_dividend, input, WIDTH bits: signed two's-complement dividend.
REQ-006 SHALL have port din_divisor, input, DWIDTH bits: unsigned divisor.
REQ-007 SHALL have port din_valid, input, 1 bit: input operands valid.
REQ-008 SHALL have port din_ready, output, 1 bit: block can accept operands.
REQ-009 SHALL have port dout_quotient, output, WIDTH bits: signed rounded quotient.
REQ-010 SHALL have port dout_dbz, output, 1 bit: divide-by-zero flag for the current result.
REQ-011 SHALL have port dout_valid, output, 1 bit: result valid.
REQ-012 SHALL have port dout_ready, input, 1 bit: downstream accepts the result.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, ROUND and DONE.
REQ-014 SHALL drive din_ready=1 only in IDLE; an accept occurs on a rising edge where din_valid=1 and din_ready=1.
REQ-015 SHALL, on accept, capture the sign of din_dividend, its magnitude |a| (WIDTH bits unsigned) and din_divisor b.
REQ-016 SHALL, on accept with b!=0, move IDLE->CALC; on accept with b==0, move IDLE->DONE.
REQ-017 SHALL, in CALC, compute one magnitude quotient bit per cycle, MSB first, by restoring division with a DWIDTH+1-bit partial remainder, for exactly WIDTH cycles, then move to ROUND.
REQ-018 SHALL, in ROUND (1 cycle), form Q+1 if 2R >= b, else Q (round half away from zero), negate if the dividend was negative, and move to DONE.
REQ-019 SHALL, for b==0, set dout_quotient to 2^(WIDTH-1)-1 when the dividend is >=0 and to -2^(WIDTH-1) when it is <0, and set dout_dbz=1; otherwise dout_dbz=0.
REQ-020 SHALL assert dout_valid only in DONE; dout_valid first goes high exactly WIDTH+2 edges after the accepting edge (b!=0), or 1 edge after it (b==0).
REQ-021 SHALL hold dout_quotient, dout_dbz and dout_valid stable in DONE while dout_ready=0.
REQ-022 SHALL move DONE->IDLE on an edge with dout_ready=1; din_ready rises on the following cycle. Accept and result handoff never occur in the same cycle, so there are no overlapping operations.
REQ-023 SHALL ignore din_valid and operand changes outside IDLE.
REQ-024 SHALL produce no arithmetic overflow:
- dividend -2^(WIDTH-1) with b=1 yields -2^(WIDTH-1).
- the rounding increment can never exceed the quotient range.
REQ-025 SHALL produce a quotient of 0 for a dividend of 0 with any b!=0 (no negative zero).

Reset
REQ-026 SHALL, while nrst=0, force the state to IDLE and set dout_valid=0, dout_quotient=0 and dout_dbz=0; din_ready=1 after reset release.
REQ-027 SHALL, on nrst asserted mid-CALC or in DONE, abort the operation immediately; no result for that operation is ever presented.
REQ-028 SHALL hold datapath registers other than the outputs and FSM unreset; their values are don't-care until the next accept.

Verification
REQ-029 SHALL cover: 100/16 and -100/16 -> dout_quotient 6 and -6, dout_dbz=0, dout_valid exactly 14 edges after accept (WIDTH=12).
REQ-030 SHALL cover the ties: 24/16 -> 2 and -24/16 -> -2; 7/16 -> 0; 8/16 -> 1; 0/5 -> 0.
REQ-031 SHALL cover the extremes: -2048/1 -> -2048; 2047/1 -> 2047; 2047/255 -> 8; -2048/255 -> -8.
REQ-032 SHALL cover divide-by-zero: 5/0 -> 2047, dout_dbz=1, 1-edge latency; -5/0 -> -2048, dout_dbz=1.
REQ-033 SHALL cover backpressure: dout_ready=0 for 10 cycles in DONE -> outputs stable and din_ready=0; dout_ready=1 -> IDLE next edge; back-to-back accept then succeeds.
REQ-034 SHALL cover reset mid-operation: nrst pulsed at CALC cycle 5 -> dout_valid never asserts for that operation; a new accept of 100/16 -> 6.
REQ-035 SHALL cover random regression: random operands, b in 0..255 -> every result matches a reference model of round-half-away-from-zero with saturation on b==0.
